// File: rtl/multiplicador_uc.sv
// multiplicador_uc: control unit for the N-bit shift-add multiplier.
// Moore FSM sequencing load, conditional add and shift, with watchdog.
module multiplicador_uc #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic qlsb,
   input  logic zero,
   output logic a_rst,
   output logic a_en,
   output logic a_ld,
   output logic b_en,
   output logic b_ld,
   output logic q_en,
   output logic q_ld,
   output logic cnt_en,
   output logic cnt_ld,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int WW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_TEST,
      S_ADD,
      S_SHIFT,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [11:0]     ctl_q, ctl_d;

   // Output pattern per state; registered so outputs follow state_q only.
   // Bit order: a_rst a_en a_ld b_en b_ld q_en q_ld cnt_en cnt_ld busy done err
   function automatic logic [11:0] decode(input state_t s);
      logic [11:0] o;
      o = '0;
      unique case (s)
         S_INIT:  o = 12'b1_00_11_11_11_1_0_0;
         S_TEST:  o = 12'b0_00_00_00_00_1_0_0;
         S_ADD:   o = 12'b0_11_00_00_00_1_0_0;
         S_SHIFT: o = 12'b0_10_00_10_10_1_0_0;
         S_DONE:  o = 12'b0_00_00_00_00_0_1_0;
         S_ERR:   o = 12'b0_00_00_00_00_0_0_1;
         default: o = '0;
      endcase
      return o;
   endfunction

   // Next-state and watchdog update.
   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_INIT;
         end
         S_INIT: begin
            wd_d    = '0;
            state_d = S_TEST;
         end
         S_TEST: begin
            if (zero)                 state_d = S_DONE;
            else if (wd_q == WW'(N))  state_d = S_ERR;
            else if (qlsb)            state_d = S_ADD;
            else                      state_d = S_SHIFT;
         end
         S_ADD: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (wd_q != WW'(N)) wd_d = wd_q + WW'(1);
            state_d = S_TEST;
         end
         S_DONE, S_ERR: begin
            if (!start) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ctl_d = decode(state_d);

   // State, watchdog and registered outputs; reset clears all at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wd_q    <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         ctl_q   <= ctl_d;
      end
   end

   assign {a_rst, a_en, a_ld, b_en, b_ld, q_en, q_ld,
           cnt_en, cnt_ld, busy, done, err} = ctl_q;

endmodule

// File: tb/tb_multiplicador_uc.sv
// tb_multiplicador_uc: random operands through a behavioural datapath,
// checked against product, latency and add-count rules.
module tb_multiplicador_uc;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst, start, qlsb, zero;
   logic a_rst, a_en, a_ld, b_en, b_ld, q_en, q_ld;
   logic cnt_en, cnt_ld, busy, done, err;
   logic [11:0] outs;

   logic [N:0]   A   = '0;
   logic [N-1:0] B   = '0;
   logic [N-1:0] Q   = '0;
   logic [N-1:0] cnt = '0;
   logic [N-1:0] b_in, q_in;
   bit force_z0  = 1'b0;
   bit force_pri = 1'b0;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   multiplicador_uc #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .qlsb(qlsb), .zero(zero),
      .a_rst(a_rst), .a_en(a_en), .a_ld(a_ld), .b_en(b_en), .b_ld(b_ld),
      .q_en(q_en), .q_ld(q_ld), .cnt_en(cnt_en), .cnt_ld(cnt_ld),
      .busy(busy), .done(done), .err(err)
   );

   assign outs = {a_rst, a_en, a_ld, b_en, b_ld, q_en, q_ld,
                  cnt_en, cnt_ld, busy, done, err};

   assign zero = force_z0 ? 1'b0 : (force_pri ? 1'b1 : (cnt == '0));
   assign qlsb = force_pri ? 1'b1 : Q[0];

   // Behavioural shift-add datapath driven by the controls.
   always @(posedge clk) begin
      if (a_rst)             A <= '0;
      else if (a_en && a_ld) A <= A + {1'b0, B};
      else if (a_en)         A <= A >> 1;
      if (b_en && b_ld)      B <= b_in;
      if (q_en && q_ld)      Q <= q_in;
      else if (q_en)         Q <= {A[0], Q[N-1:1]};
      if (cnt_en && cnt_ld)  cnt <= N[N-1:0];
      else if (cnt_en)       cnt <= cnt - 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run(input logic [N-1:0] b, input logic [N-1:0] q,
                      output int edges, output int adds,
                      output int shifts);
      bit ok;
      b_in = b;
      q_in = q;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      edges = 1; adds = 0; shifts = 0; ok = 1'b0;
      #1;
      chk("init", {28'd0, a_rst, b_ld, q_ld, cnt_ld}, 32'hF);
      for (int i = 0; i < 200; i++) begin
         if (done || err) begin
            ok = 1'b1;
            break;
         end
         chk("busy", {31'd0, busy}, 32'd1);
         chk("arst_ald", {31'd0, a_rst & a_ld}, 32'd0);
         if (a_en && a_ld)     adds++;
         if (cnt_en && !cnt_ld) shifts++;
         @(posedge clk);
         edges++;
         #1;
      end
      if (!ok) chk("timeout", 32'd0, 32'd1);
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_ctl", {23'd0, outs[11:3]}, 32'd0);
   endtask

   task automatic fin(input int hold, input bit want_err);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_done", {31'd0, done}, {31'd0, !want_err});
         chk("hold_err", {31'd0, err}, {31'd0, want_err});
         chk("no_init", {31'd0, b_ld}, 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("to_idle", {20'd0, outs}, 32'd0);
   endtask

   task automatic op(input logic [N-1:0] b, input logic [N-1:0] q,
                     input int hold);
      int e, ad, sh, pc, prod;
      pc   = $countones(q);
      prod = int'(b) * int'(q);
      run(b, q, e, ad, sh);
      chk("done", {31'd0, done}, 32'd1);
      chk("latency", e, 3 + 2 * N + pc);
      chk("adds", ad, pc);
      chk("shifts", sh, N);
      chk("product", {24'd0, A[N-1:0], Q}, prod);
      fin(hold, 1'b0);
   endtask

   initial begin
      int e, ad, sh;
      bit found;
      rst = 1'b1;
      start = 1'b0;
      b_in = '0;
      q_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {20'd0, outs}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle", {20'd0, outs}, 32'd0);

      op(4'b0110, 4'b0000, 2);
      op(4'b0110, 4'b0101, 3);
      op(4'b1111, 4'b1111, 0);
      for (int k = 0; k < 8; k++)
         op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

      force_z0 = 1'b1;
      q_in = 4'($urandom);
      run(4'($urandom), q_in, e, ad, sh);
      chk("wd_err", {31'd0, err}, 32'd1);
      chk("wd_done", {31'd0, done}, 32'd0);
      chk("wd_shifts", sh, N);
      chk("wd_latency", e, 3 + 2 * N + $countones(q_in));
      fin(3, 1'b1);
      force_z0 = 1'b0;

      force_pri = 1'b1;
      run(4'd3, 4'd1, e, ad, sh);
      chk("pri_done", {31'd0, done}, 32'd1);
      chk("pri_latency", e, 3);
      chk("pri_adds", ad, 0);
      fin(1, 1'b0);
      force_pri = 1'b0;

      b_in = 4'd6;
      q_in = 4'd5;
      @(negedge clk);
      start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (cnt_en && !cnt_ld) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_shift", {31'd0, found}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", {20'd0, outs}, 32'd0);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_idle", {20'd0, outs}, 32'd0);

      op(4'd9, 4'd7, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
